// File: rtl/fp_operand_unpack_pkg.sv
// ============================================================================
// Module      : fp_operand_unpack_pkg
// Description : Shared FP adder configuration: field widths and the 3-bit
//               operand type codes used by the unpacker and special detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_operand_unpack_pkg;

  localparam int c_exp_size    = 8;
  localparam int c_mantis_size = 23;

  localparam logic [2:0] c_type_zero      = 3'b000;
  localparam logic [2:0] c_type_inf       = 3'b001;
  localparam logic [2:0] c_type_subnormal = 3'b010;
  localparam logic [2:0] c_type_normal    = 3'b011;
  localparam logic [2:0] c_type_nan       = 3'b100;

endpackage

`default_nettype wire

// File: rtl/fp_classify.sv
// ============================================================================
// Module      : fp_classify
// Description : Combinational field split and type classification of one
//               packed {sign, exp, mantis} operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_classify
  import fp_operand_unpack_pkg::*;
#(
  parameter int EXP_SIZE    = c_exp_size,
  parameter int MANTIS_SIZE = c_mantis_size
) (
  input  logic [EXP_SIZE+MANTIS_SIZE:0] word,
  output logic                          sign,
  output logic [EXP_SIZE-1:0]           exp,
  output logic [MANTIS_SIZE-1:0]        mantis,
  output logic [2:0]                    fp_type,
  output logic                          snan
);

  logic w_exp_zero;
  logic w_exp_ones;
  logic w_man_zero;

  always_comb begin
    sign       = word[EXP_SIZE+MANTIS_SIZE];
    exp        = word[EXP_SIZE+MANTIS_SIZE-1:MANTIS_SIZE];
    mantis     = word[MANTIS_SIZE-1:0];
    w_exp_zero = (exp == '0);
    w_exp_ones = &exp;
    w_man_zero = (mantis == '0);
    fp_type    = c_type_normal;
    if (w_exp_zero) begin
      fp_type = w_man_zero ? c_type_zero : c_type_subnormal;
    end else if (w_exp_ones) begin
      fp_type = w_man_zero ? c_type_inf : c_type_nan;
    end
    // A clear mantissa MSB marks a signalling NaN; payload is left untouched.
    snan = w_exp_ones && !w_man_zero && !mantis[MANTIS_SIZE-1];
  end

endmodule

`default_nettype wire

// File: rtl/fp_operand_unpack.sv
// ============================================================================
// Module      : fp_operand_unpack
// Description : Two-stage valid/ready front end of the FP adder: unpacks,
//               classifies and derives significand/leading-zero count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_operand_unpack
  import fp_operand_unpack_pkg::*;
#(
  parameter int EXP_SIZE    = c_exp_size,
  parameter int MANTIS_SIZE = c_mantis_size,
  localparam int LZ_W       = $clog2(MANTIS_SIZE + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_SIZE+MANTIS_SIZE:0] op_A,
  input  logic [EXP_SIZE+MANTIS_SIZE:0] op_B,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          sign_A,
  output logic                          sign_B,
  output logic [EXP_SIZE-1:0]           exp_A,
  output logic [EXP_SIZE-1:0]           exp_B,
  output logic [MANTIS_SIZE-1:0]        mantis_A,
  output logic [MANTIS_SIZE-1:0]        mantis_B,
  output logic [2:0]                    type_A,
  output logic [2:0]                    type_B,
  output logic [MANTIS_SIZE:0]          sig_A,
  output logic [MANTIS_SIZE:0]          sig_B,
  output logic [LZ_W-1:0]               lz_A,
  output logic [LZ_W-1:0]               lz_B,
  output logic                          snan_A,
  output logic                          snan_B
);

  localparam int W = 1 + EXP_SIZE + MANTIS_SIZE;

  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s1_adv;
  logic w_s2_adv;

  logic [1:0]                  w_out_sign;
  logic [1:0][EXP_SIZE-1:0]    w_out_exp;
  logic [1:0][MANTIS_SIZE-1:0] w_out_mantis;
  logic [1:0][2:0]             w_out_type;
  logic [1:0][MANTIS_SIZE:0]   w_out_sig;
  logic [1:0][LZ_W-1:0]        w_out_lz;
  logic [1:0]                  w_out_snan;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_op
    logic [W-1:0]           w_op;
    logic                   w_sign;
    logic [EXP_SIZE-1:0]    w_exp;
    logic [MANTIS_SIZE-1:0] w_mantis;
    logic [2:0]             w_type;
    logic                   w_snan;
    logic [LZ_W-1:0]        w_lz;

    logic                   r_s1_sign;
    logic [EXP_SIZE-1:0]    r_s1_exp;
    logic [MANTIS_SIZE-1:0] r_s1_mantis;
    logic [2:0]             r_s1_type;
    logic                   r_s1_snan;

    logic                   r_s2_sign;
    logic [EXP_SIZE-1:0]    r_s2_exp;
    logic [MANTIS_SIZE-1:0] r_s2_mantis;
    logic [2:0]             r_s2_type;
    logic                   r_s2_snan;
    logic [MANTIS_SIZE:0]   r_s2_sig;
    logic [LZ_W-1:0]        r_s2_lz;

    assign w_op = (g == 0) ? op_A : op_B;

    fp_classify #(
      .EXP_SIZE    (EXP_SIZE),
      .MANTIS_SIZE (MANTIS_SIZE)
    ) u_classify (
      .word    (w_op),
      .sign    (w_sign),
      .exp     (w_exp),
      .mantis  (w_mantis),
      .fp_type (w_type),
      .snan    (w_snan)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_sign   <= 1'b0;
        r_s1_exp    <= '0;
        r_s1_mantis <= '0;
        r_s1_type   <= c_type_zero;
        r_s1_snan   <= 1'b0;
      end else if (w_s1_adv && in_valid) begin
        r_s1_sign   <= w_sign;
        r_s1_exp    <= w_exp;
        r_s1_mantis <= w_mantis;
        r_s1_type   <= w_type;
        r_s1_snan   <= w_snan;
      end
    end

    // Ascending scan: the highest set bit is written last and wins.
    always_comb begin
      w_lz = '0;
      for (int i = 0; i < MANTIS_SIZE; i++) begin
        if (r_s1_mantis[i]) w_lz = LZ_W'(MANTIS_SIZE - 1 - i);
      end
      if (r_s1_type != c_type_subnormal) w_lz = '0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_sign   <= 1'b0;
        r_s2_exp    <= '0;
        r_s2_mantis <= '0;
        r_s2_type   <= c_type_zero;
        r_s2_snan   <= 1'b0;
        r_s2_sig    <= '0;
        r_s2_lz     <= '0;
      end else if (w_s2_adv && r_s1_valid) begin
        r_s2_sign   <= r_s1_sign;
        r_s2_exp    <= r_s1_exp;
        r_s2_mantis <= r_s1_mantis;
        r_s2_type   <= r_s1_type;
        r_s2_snan   <= r_s1_snan;
        r_s2_sig    <= {(r_s1_type == c_type_normal), r_s1_mantis};
        r_s2_lz     <= w_lz;
      end
    end

    assign w_out_sign[g]   = r_s2_sign;
    assign w_out_exp[g]    = r_s2_exp;
    assign w_out_mantis[g] = r_s2_mantis;
    assign w_out_type[g]   = r_s2_type;
    assign w_out_snan[g]   = r_s2_snan;
    assign w_out_sig[g]    = r_s2_sig;
    assign w_out_lz[g]     = r_s2_lz;
  end

  assign sign_A   = w_out_sign[0];
  assign sign_B   = w_out_sign[1];
  assign exp_A    = w_out_exp[0];
  assign exp_B    = w_out_exp[1];
  assign mantis_A = w_out_mantis[0];
  assign mantis_B = w_out_mantis[1];
  assign type_A   = w_out_type[0];
  assign type_B   = w_out_type[1];
  assign sig_A    = w_out_sig[0];
  assign sig_B    = w_out_sig[1];
  assign lz_A     = w_out_lz[0];
  assign lz_B     = w_out_lz[1];
  assign snan_A   = w_out_snan[0];
  assign snan_B   = w_out_snan[1];

endmodule

`default_nettype wire

// File: tb/tb_fp_operand_unpack.sv
// ============================================================================
// Module      : tb_fp_operand_unpack
// Description : Self-checking bench for fp_operand_unpack with a scoreboard
//               and an arithmetic reference model of the unpacked fields.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_operand_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_A;
  logic [31:0] op_B;
  logic        out_valid;
  logic        out_ready;
  logic        sign_A, sign_B;
  logic [7:0]  exp_A, exp_B;
  logic [22:0] mantis_A, mantis_B;
  logic [2:0]  type_A, type_B;
  logic [23:0] sig_A, sig_B;
  logic [4:0]  lz_A, lz_B;
  logic        snan_A, snan_B;

  int n_vec = 0;
  int n_err = 0;
  int n_push = 0;
  int n_pop = 0;
  int cyc = 0;
  logic [63:0] q[$];

  fp_operand_unpack u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_A      (op_A),
    .op_B      (op_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_A    (sign_A),
    .sign_B    (sign_B),
    .exp_A     (exp_A),
    .exp_B     (exp_B),
    .mantis_A  (mantis_A),
    .mantis_B  (mantis_B),
    .type_A    (type_A),
    .type_B    (type_B),
    .sig_A     (sig_A),
    .sig_B     (sig_B),
    .lz_A      (lz_A),
    .lz_B      (lz_B),
    .snan_A    (snan_A),
    .snan_B    (snan_B)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model straight from the IEEE field rules.
  task automatic model(input logic [31:0] x, output logic s, output logic [7:0] e,
                       output logic [22:0] m, output logic [2:0] t,
                       output logic [23:0] sig, output logic [4:0] lz, output logic sn);
    s  = x[31];
    e  = x[30:23];
    m  = x[22:0];
    lz = 5'd0;
    if (e == 8'd0)        t = (m == 23'd0) ? 3'd0 : 3'd2;
    else if (e == 8'd255) t = (m == 23'd0) ? 3'd1 : 3'd4;
    else                  t = 3'd3;
    sig = (t == 3'd3) ? ({1'b0, m} + 24'd8388608) : {1'b0, m};
    if (t == 3'd2) begin
      for (int k = 22; k >= 0; k--) begin
        if (int'(m) >= (1 << k)) begin
          lz = 5'(22 - k);
          break;
        end
      end
    end
    sn = (t == 3'd4) && (int'(m) < (1 << 22));
  endtask

  task automatic cmp_out(input logic [31:0] a, input logic [31:0] b);
    logic s; logic [7:0] e; logic [22:0] m; logic [2:0] t;
    logic [23:0] sg; logic [4:0] lz; logic sn;
    model(a, s, e, m, t, sg, lz, sn);
    check("sign_A", 32'(sign_A), 32'(s));
    check("exp_A", 32'(exp_A), 32'(e));
    check("mantis_A", 32'(mantis_A), 32'(m));
    check("type_A", 32'(type_A), 32'(t));
    check("sig_A", 32'(sig_A), 32'(sg));
    check("lz_A", 32'(lz_A), 32'(lz));
    check("snan_A", 32'(snan_A), 32'(sn));
    model(b, s, e, m, t, sg, lz, sn);
    check("sign_B", 32'(sign_B), 32'(s));
    check("exp_B", 32'(exp_B), 32'(e));
    check("mantis_B", 32'(mantis_B), 32'(m));
    check("type_B", 32'(type_B), 32'(t));
    check("sig_B", 32'(sig_B), 32'(sg));
    check("lz_B", 32'(lz_B), 32'(lz));
    check("snan_B", 32'(snan_B), 32'(sn));
  endtask

  // Scoreboard: every accepted pair must emerge once, in order, held while stalled.
  always @(negedge clk) begin
    logic [63:0] front;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          front = q[0];
          cmp_out(front[63:32], front[31:0]);
          if (out_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({op_A, op_B});
        n_push++;
      end
    end
  end

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    int          k;
    k = $urandom_range(0, 5);
    m = 23'($urandom);
    if ($urandom_range(0, 3) == 0) m = m >> $urandom_range(0, 22);
    case (k)
      0:       e = 8'd0;
      1:       begin e = 8'd0; m = 23'd0; end
      2:       begin e = 8'hFF; if ($urandom_range(0, 1) == 1) m = 23'd0; end
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the pair on the bus until it is accepted; leaves in_valid high.
  task automatic push(input logic [31:0] a, input logic [31:0] b);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    op_A     = a;
    op_B     = b;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      step();
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op_A     = 32'd0;
    op_B     = 32'd0;
  endtask

  // Single pair with out_ready high: out_valid must rise exactly two edges after acceptance.
  task automatic directed(input logic [31:0] a, input logic [31:0] b);
    push(a, b);
    idle();
    @(negedge clk);
    check("latency_cycle1_out_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check("latency_cycle2_out_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    int c0;
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (3) step();
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sig_A", 32'(sig_A), 32'd0);
    check("reset_type_B", 32'(type_B), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    step();

    directed(32'h3F800000, 32'h00000001);
    check("one_type_A", 32'(type_A), 32'h3);
    check("one_sig_A", 32'(sig_A), 32'h800000);
    check("one_lz_A", 32'(lz_A), 32'd0);
    check("denorm_type_B", 32'(type_B), 32'h2);
    check("denorm_sig_B", 32'(sig_B), 32'h000001);
    check("denorm_lz_B", 32'(lz_B), 32'd22);
    step();

    directed(32'h7F800000, 32'h7F800001);
    check("inf_type_A", 32'(type_A), 32'h1);
    check("inf_snan_A", 32'(snan_A), 32'd0);
    check("snan_type_B", 32'(type_B), 32'h4);
    check("snan_snan_B", 32'(snan_B), 32'd1);
    check("snan_mantis_B", 32'(mantis_B), 32'h000001);
    step();

    directed(32'h80000000, 32'hFFC00000);
    check("negzero_sign_A", 32'(sign_A), 32'd1);
    check("negzero_type_A", 32'(type_A), 32'h0);
    check("negzero_lz_A", 32'(lz_A), 32'd0);
    check("qnan_type_B", 32'(type_B), 32'h4);
    check("qnan_snan_B", 32'(snan_B), 32'd0);
    check("qnan_sign_B", 32'(sign_B), 32'd1);
    step();

    // Five back-to-back pairs with a three-cycle output stall.
    fork
      begin
        for (int i = 0; i < 5; i++) push(rand_op(), rand_op());
        idle();
      end
      begin
        step();
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b1;
      end
    join
    repeat (8) step();
    check("stall_drain_empty", 32'(q.size()), 32'd0);

    // Streaming: 16 pairs in 16 cycles, all out two edges after the last accept.
    p0 = n_pop;
    c0 = cyc;
    for (int i = 0; i < 16; i++) push(rand_op(), rand_op());
    idle();
    check("stream_accept_cycles", 32'(cyc - c0), 32'd16);
    step();
    step();
    check("stream_pop_count", 32'(n_pop - p0), 32'd16);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    push(rand_op(), rand_op());
    push(rand_op(), rand_op());
    idle();
    @(negedge clk);
    check("rst_pre_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_type_A", 32'(type_A), 32'd0);
    check("rst_mid_sig_B", 32'(sig_B), 32'd0);
    check("rst_mid_exp_A", 32'(exp_A), 32'd0);
    step();
    directed(rand_op(), rand_op());
    repeat (4) step();
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_operand_unpack.md
Name: fp_operand_unpack

Overview:
Front end of the FP adder datapath. Accepts two packed IEEE-style operands through a valid/ready handshake and splits each into sign, exponent and mantissa fields. It classifies each operand into the shared 3-bit type code and derives the hidden-bit significand and the subnormal leading-zero count. Its outputs drive the special-case detector and the alignment stage; it produces the `type_A`/`type_B` codes those stages consume.

Parameters:
EXP_SIZE, `EXP_SIZE (8), exponent field width
MANTIS_SIZE, `MANTIS_SIZE (23), stored mantissa field width
LZ_W, $clog2(MANTIS_SIZE+1) (5), width of leading-zero count (localparam)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operand pair this cycle
op_A  in  1+EXP_SIZE+MANTIS_SIZE  packed operand A {sign, exp, mantis}
op_B  in  1+EXP_SIZE+MANTIS_SIZE  packed operand B
out_valid  out  1  unpacked pair valid
out_ready  in  1  downstream accepts pair
sign_A, sign_B  out  1  sign fields
exp_A, exp_B  out  EXP_SIZE  raw exponent fields
mantis_A, mantis_B  out  MANTIS_SIZE  raw mantissa fields
type_A, type_B  out  3  ZERO=000, INF=001, SUBNORMAL=010, NORMAL=011, NAN=100
sig_A, sig_B  out  MANTIS_SIZE+1  {hidden bit, mantis}; hidden bit = (type==NORMAL)
lz_A, lz_B  out  LZ_W  leading zeros of mantis if SUBNORMAL, else 0
snan_A, snan_B  out  1  NaN with mantis MSB = 0 (signalling)

Behaviour:
- Classification per operand, with E = exp and M = mantis:
  - E==0, M==0 -> ZERO.
  - E==0, M!=0 -> SUBNORMAL.
  - E==all-ones, M==0 -> INF.
  - E==all-ones, M!=0 -> NAN.
  - Otherwise -> NORMAL.
- Sign of a zero is preserved (-0 passes with sign=1). NaN payload is passed unmodified; no quieting here.
- Two-stage pipeline, latency 2 cycles from in_valid&&in_ready to out_valid. Throughput is 1 pair per cycle when out_ready is held high.
  - S1 registers: fields, type, snan.
  - S2 registers: the S1 contents plus sig and lz (priority encoder over mantis, MSB first).
- Handshake: transfer occurs when valid&&ready at a rising edge.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from registered valids and out_ready.
  - Registers load only when their stage advances. Output data is held stable while out_valid && !out_ready.
- valid may not depend on ready upstream. The block never drops or duplicates a pair; order is preserved.
- lz range is 0..MANTIS_SIZE-1 for SUBNORMAL (M!=0 guarantees <MANTIS_SIZE). It is exactly 0 for every other type.
- Reset: s1_valid, s2_valid, out_valid = 0; all data outputs = 0; in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation discards in-flight pairs; no output valid until new input.
- Simultaneous output pop and input push with both stages full: all stages advance, no bubble.

Decomposition:
- Shared package/include (configuration.v): the type-code constants ZERO/INF/SUBNORMAL/NORMAL/NAN. These are moved there from local parameters so the detector and this block share one definition. Also holds EXP_SIZE/MANTIS_SIZE defines.
- One sub-module, fp_classify: combinational, one instance per operand. Takes a packed word and returns sign, exp, mantis, type and snan.
- The leading-zero encoder stays inline in S2.

Test Plan:
- op_A=0x3F800000, op_B=0x00000001, out_ready=1 -> 2 cycles later:
  - A: type_A=011, sig_A=0x800000, lz_A=0.
  - B: type_B=010, sig_B=0x000001, lz_B=22.
- op_A=0x7F800000, op_B=0x7F800001 -> type_A=001, snan_A=0; type_B=100, snan_B=1, mantis_B=0x000001.
- op_A=0x80000000, op_B=0xFFC00000 -> sign_A=1, type_A=000, lz_A=0; type_B=100, snan_B=0, sign_B=1.
- Back-to-back 5 pairs, out_ready low 3 cycles mid-stream -> in_ready low after 2 held pairs; outputs stable while stalled; all 5 emerge in order, none lost.
- Streaming 16 random pairs with out_ready=1 -> one out_valid per cycle after 2-cycle fill; each field matches the reference model.
- rst asserted while both stages valid -> next cycle out_valid=0, outputs 0, in_ready=1; a fresh pair emerges exactly 2 cycles after acceptance.
